// File: rtl/dmem_lsu.sv
`default_nettype none
// =============================================================================
// dmem_lsu : load/store unit driving a word-indexed data memory (sub-word RMW,
//            sign/zero-extended loads). Macro DMEM_LSU_MISALIGN_TRAP_EN: trap.
// Revision : 1.0
// =============================================================================
module dmem_lsu #(
  parameter int MEMORY_TYPE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_we_q;
  logic [31:0] r_addr_q;
  logic [1:0]  r_size_q;
  logic        r_unsigned_q;
  logic [31:0] r_wdata_q;
  logic [31:0] r_rdata_q;
  logic [31:0] r_wd_q;
  logic        w_accept;
  logic        w_misalign;
  logic        w_capture;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merge;

  assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  logic r_err_q;
  assign w_misalign = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign rsp_err    = r_err_q;
`else
  assign w_misalign = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // Combinational-read RAM is sampled in RD; BSRAM data arrives in RWAIT.
  assign w_capture = ((r_state == S_RD) && (MEMORY_TYPE == 0)) || (r_state == S_RWAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misalign)                 w_next = S_RESP;
          else if (req_we && req_size[1]) w_next = S_WR;
          else                            w_next = S_RD;
        end
      end
      S_RD: begin
        if (MEMORY_TYPE != 0) w_next = S_RWAIT;
        else                  w_next = r_we_q ? S_WR : S_RESP;
      end
      S_RWAIT: w_next = r_we_q ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    mem_we    = (r_state == S_WR);
  end

  // size[1] set means a full word (size 11 only reaches here untrapped).
  always_comb begin
    w_byte = mem_rd[{r_addr_q[1:0], 3'b000} +: 8];
    w_half = mem_rd[{r_addr_q[1], 4'b0000} +: 16];
    case (r_size_q)
      2'b00:   w_load_val = r_unsigned_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_val = r_unsigned_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_val = mem_rd;
    endcase
    w_merge = mem_rd;
    if (r_size_q == 2'b00) w_merge[{r_addr_q[1:0], 3'b000} +: 8]  = r_wdata_q[7:0];
    else                   w_merge[{r_addr_q[1], 4'b0000} +: 16] = r_wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_q       <= 1'b0;
      r_addr_q     <= 32'd0;
      r_size_q     <= 2'd0;
      r_unsigned_q <= 1'b0;
      r_wdata_q    <= 32'd0;
      r_rdata_q    <= 32'd0;
      r_wd_q       <= 32'd0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      r_err_q      <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_we_q       <= req_we;
        r_addr_q     <= req_addr;
        r_size_q     <= req_size;
        r_unsigned_q <= req_unsigned;
        r_wdata_q    <= req_wdata;
        r_rdata_q    <= 32'd0;
        r_wd_q       <= req_wdata;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        r_err_q      <= w_misalign;
`endif
      end
      if (w_capture) begin
        if (r_we_q) r_wd_q    <= w_merge;
        else        r_rdata_q <= w_load_val;
      end
    end
  end

  assign mem_a     = {2'b00, r_addr_q[31:2]};
  assign mem_wd    = r_wd_q;
  assign rsp_rdata = r_rdata_q;

endmodule
`default_nettype wire
